// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated, ready-handshaked word memory for the CPU data bus.
// A request is latched in IDLE, held for WAIT_CYCLES, performed once, then
// acknowledged with a one-cycle dm_ready pulse followed by a turnaround cycle.
module dmem_responder #(
    parameter int ADDR_W      = 11,
    parameter int DEPTH       = 2048,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_r,
    input  logic              dm_w,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              dm_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable as the limit.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_op_w;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH];

    logic                w_in_range;
    logic                w_access;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_idx;

    assign w_in_range = ({1'b0, r_addr} < LIMIT);
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Reset gating keeps an aborted write from landing on a coincident edge.
    assign w_mem_we   = w_access && r_op_w && w_in_range && !rst;

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Request FSM with registered ready/error/read-data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_w   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            dm_rdata <= '0;
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
        end else begin
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dm_r ^ dm_w) begin
                        r_op_w  <= dm_w;
                        r_addr  <= dm_addr;
                        r_wdata <= dm_wdata;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end else if (dm_r && dm_w) begin
                        dm_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        dm_ready <= 1'b1;
                        dm_err   <= !w_in_range;
                        if (!r_op_w) begin
                            dm_rdata <= w_in_range ? r_mem[w_idx] : '0;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: instance A (WAIT_CYCLES=2, DEPTH=1024)
// covers reset, write/read, illegal strobes, range errors and input stability;
// instance B (WAIT_CYCLES=0, DEPTH=2048) covers back-to-back throughput.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        a_r, a_w;
    logic [10:0] a_addr;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_ready, a_err;

    logic        b_r, b_w;
    logic [10:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        b_ready, b_err;

    int          checks;
    int          errors;
    exp_t        sb[$];

    // Reference model for instance A
    logic [31:0] mdl [int];
    logic [31:0] last_rd;

    dmem_responder #(.ADDR_W(11), .DEPTH(1024), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .dm_r(a_r), .dm_w(a_w), .dm_addr(a_addr),
        .dm_wdata(a_wdata), .dm_rdata(a_rdata), .dm_ready(a_ready), .dm_err(a_err)
    );

    dmem_responder #(.ADDR_W(11), .DEPTH(2048), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .dm_r(b_r), .dm_w(b_w), .dm_addr(b_addr),
        .dm_wdata(b_wdata), .dm_rdata(b_rdata), .dm_ready(b_ready), .dm_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result of an access on instance A; updates the model.
    function automatic exp_t predict(input logic is_rd, input logic [10:0] addr,
                                     input logic [31:0] wd);
        exp_t e;
        e.err = (addr >= 11'd1024);
        if (is_rd) begin
            e.rdata = e.err ? 32'h0 : mdl[int'(addr)];
            last_rd = e.rdata;
        end else begin
            if (!e.err) mdl[int'(addr)] = wd;
            e.rdata = last_rd;
        end
        return e;
    endfunction

    // Drives one request on A, holds it until dm_ready (bounded), returns what was seen.
    task automatic access(input logic r, input logic w, input logic [10:0] addr,
                          input logic [31:0] wd, input bit chg, input logic [10:0] addr2,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic ready_after);
        a_r = r; a_w = w; a_addr = addr; a_wdata = wd;
        lat = -1; rd = 'x; er = 'x;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (chg && i == 1) a_addr = addr2;
            if (a_ready) begin
                lat = i; rd = a_rdata; er = a_err;
                break;
            end
        end
        a_r = 1'b0; a_w = 1'b0;
        step();
        ready_after = a_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_r = 0; a_w = 0; a_addr = '0; a_wdata = '0;
        b_r = 0; b_w = 0; b_addr = '0; b_wdata = '0;
        last_rd = '0;
        #1;
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp %h", a_rdata, 32'h0); end
        step(); step();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", a_ready); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", a_err); end
        checks++; if (b_ready !== 1'b0 || b_err !== 1'b0 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_b got %b%b %h exp 00 0", b_ready, b_err, b_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] rd; logic er, ra; int lat;
        sb.push_back(predict(1'b0, 11'h010, 32'h12345678));
        access(1'b0, 1'b1, 11'h010, 32'h12345678, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency got %0d exp 4", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b exp 0", ra); end
        checks++; if (er !== e.err || rd !== e.rdata) begin
            errors++; $display("FAIL wr_resp got %b %h exp %b %h", er, rd, e.err, e.rdata);
        end
        sb.push_back(predict(1'b1, 11'h010, '0));
        access(1'b1, 1'b0, 11'h010, 32'h0, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got %0d exp 4", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", ra); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL rd_data got %h exp %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL rd_err got %b exp %b", er, e.err); end
    endtask

    task automatic test_both_strobes();
        exp_t e;
        logic [31:0] rd; logic er, ra; int lat;
        int n_err, n_rdy;
        n_err = 0; n_rdy = 0;
        a_r = 1'b1; a_w = 1'b1; a_addr = 11'h010; a_wdata = 32'hAAAAAAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_err) n_err++;
            if (a_ready) n_rdy++;
        end
        a_r = 1'b0; a_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_err) n_err++;
            if (a_ready) n_rdy++;
        end
        checks++; if (n_err !== 3) begin errors++; $display("FAIL both_err_cycles got %0d exp 3", n_err); end
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL both_ready_cycles got %0d exp 0", n_rdy); end
        sb.push_back(predict(1'b1, 11'h010, '0));
        access(1'b1, 1'b0, 11'h010, 32'h0, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL both_mem_kept got %h exp %h", rd, e.rdata); end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        logic [31:0] rd; logic er, ra; int lat;
        int n_rdy;
        sb.push_back(predict(1'b0, 11'd5, 32'h11111111));
        access(1'b0, 1'b1, 11'd5, 32'h11111111, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        sb.push_back(predict(1'b1, 11'd5, '0));
        access(1'b1, 1'b0, 11'd5, 32'h0, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL pre_abort_rd got %h exp %h", rd, e.rdata); end
        // Write DEADBEEF to 5, then reset while the counter is still running.
        a_w = 1'b1; a_addr = 11'd5; a_wdata = 32'hDEADBEEF;
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++; if (a_rdata !== 32'h0 || a_ready !== 1'b0 || a_err !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got %b%b %h exp 00 0", a_ready, a_err, a_rdata);
        end
        last_rd = '0;
        a_w = 1'b0;
        step();
        rst = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_ready) n_rdy++;
        end
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL abort_stray_ready got %0d exp 0", n_rdy); end
        sb.push_back(predict(1'b1, 11'd5, '0));
        access(1'b1, 1'b0, 11'd5, 32'h0, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL abort_mem got %h exp %h", rd, e.rdata); end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [31:0] rd; logic er, ra; int lat;
        sb.push_back(predict(1'b0, 11'h400, 32'hFFFFFFFF));
        access(1'b0, 1'b1, 11'h400, 32'hFFFFFFFF, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (lat !== 4 || er !== e.err) begin
            errors++; $display("FAIL oor_wr got lat %0d err %b exp lat 4 err %b", lat, er, e.err);
        end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL oor_wr_rdata got %h exp %h", rd, e.rdata); end
        sb.push_back(predict(1'b1, 11'h400, '0));
        access(1'b1, 1'b0, 11'h400, 32'h0, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (lat !== 4 || er !== e.err) begin
            errors++; $display("FAIL oor_rd got lat %0d err %b exp lat 4 err %b", lat, er, e.err);
        end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL oor_rd_data got %h exp %h", rd, e.rdata); end
        checks++; if (ra !== 1'b0 || a_err !== 1'b0) begin
            errors++; $display("FAIL oor_err_pulse got %b%b exp 00", ra, a_err);
        end
    endtask

    task automatic test_addr_change();
        exp_t e;
        logic [31:0] rd; logic er, ra; int lat;
        sb.push_back(predict(1'b0, 11'd3, 32'h33333333));
        access(1'b0, 1'b1, 11'd3, 32'h33333333, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        sb.push_back(predict(1'b0, 11'd7, 32'h77777777));
        access(1'b0, 1'b1, 11'd7, 32'h77777777, 1'b0, '0, rd, er, lat, ra);
        e = sb.pop_front();
        sb.push_back(predict(1'b1, 11'd3, '0));
        access(1'b1, 1'b0, 11'd3, 32'h0, 1'b1, 11'd7, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL addr_latched got %h exp %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL addr_latched_err got %b exp %b", er, e.err); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   got;
        logic exp_rdy;
        // Seed instance B's memory.
        got = 1'b0;
        b_w = 1'b1; b_addr = 11'd9; b_wdata = 32'hCAFE0009;
        for (int i = 0; i < 10; i++) begin
            step();
            if (b_ready) begin got = 1'b1; break; end
        end
        b_w = 1'b0;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_seed got %b exp 1", got); end
        step();
        for (int i = 0; i < 4; i++) sb.push_back('{rdata: 32'hCAFE0009, err: 1'b0});
        b_r = 1'b1; b_addr = 11'd9;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_rdy = ((k % 3) == 2);
            checks++; if (b_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_ready_c%0d got %b exp %b", k, b_ready, exp_rdy);
            end
            if (b_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (b_rdata !== e.rdata || b_err !== e.err) begin
                    errors++; $display("FAIL b2b_data_c%0d got %h %b exp %h %b", k, b_rdata, b_err, e.rdata, e.err);
                end
            end
        end
        b_r = 1'b0;
        step(); step();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_both_strobes();
        test_reset_abort();
        test_out_of_range();
        test_addr_change();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
